// File: rtl/motor_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_sequencer
// Description : Motor speed controller. Derives a tick enable from i_clk,
//               generates a fixed-period PWM, ramps duty between speed
//               levels at PWM period boundaries and runs a seconds-resolution
//               timer that forces a controlled stop when it expires.
//               Optional feature macro: MOTOR_SOFT_START_EN (duty ramps by
//               RAMP_STEP per period); undefined, duty jumps to its target.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_sequencer #(
    parameter int CLK_DIV       = 100,
    parameter int PWM_PERIOD    = 100,
    parameter int DUTY_LO       = 30,
    parameter int DUTY_MID      = 60,
    parameter int DUTY_HI       = 90,
    parameter int RAMP_STEP     = 5,
    parameter int TICKS_PER_SEC = 1_000_000,
    localparam int DW           = $clog2(PWM_PERIOD + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_speed,
    input  logic          i_speed_valid,
    input  logic [7:0]    i_timer_set,
    input  logic          i_timer_load,
    output logic          o_pwm,
    output logic [DW-1:0] o_duty,
    output logic [1:0]    o_state,
    output logic [7:0]    o_remaining,
    output logic          o_timeout
);

    localparam int c_presc_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_sec_w   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);
    localparam logic [c_sec_w-1:0]   c_sec_max   = c_sec_w'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0]        c_pwm_max   = DW'(PWM_PERIOD - 1);
    localparam logic [DW-1:0]        c_step      = DW'(RAMP_STEP);
    localparam logic [DW-1:0]        c_duty_lo   = DW'(DUTY_LO);
    localparam logic [DW-1:0]        c_duty_mid  = DW'(DUTY_MID);
    localparam logic [DW-1:0]        c_duty_hi   = DW'(DUTY_HI);

`ifdef MOTOR_SOFT_START_EN
    localparam logic c_soft = 1'b1;
`else
    localparam logic c_soft = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_presc_w-1:0]   r_presc;
    logic [DW-1:0]          r_pwm_cnt;
    logic [DW-1:0]          r_duty;
    logic [DW-1:0]          r_target;
    logic [DW-1:0]          w_target_sel;
    logic [DW-1:0]          w_diff;
    logic [DW-1:0]          w_duty_ramp;
    logic [DW-1:0]          w_duty_nxt;
    logic [c_sec_w-1:0]     r_sec_cnt;
    logic [7:0]             r_remaining;
    logic                   r_timeout;
    logic                   r_pwm;
    logic                   w_tick;
    logic                   w_period_end;
    logic                   w_timer_run;
    logic                   w_sec_wrap;
    logic                   w_timeout;

    assign w_tick       = (r_presc == c_presc_max);
    assign w_period_end = w_tick && (r_pwm_cnt == c_pwm_max);

    // Timer runs only while the motor is commanded on and time is left
    assign w_timer_run  = (r_state != ST_IDLE) && (r_target != '0) && (r_remaining != 8'd0);
    assign w_sec_wrap   = w_timer_run && w_tick && (r_sec_cnt == c_sec_max);
    // A simultaneous load takes precedence and suppresses the expiry
    assign w_timeout    = w_sec_wrap && (r_remaining == 8'd1) && !i_timer_load;

    // Prescaler and PWM position counter; the tick is an enable only
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_presc   <= '0;
                r_pwm_cnt <= (r_pwm_cnt == c_pwm_max) ? '0 : r_pwm_cnt + DW'(1);
            end else begin
                r_presc <= r_presc + c_presc_w'(1);
            end
        end
    end

    // Speed code to target duty lookup
    always_comb begin
        w_target_sel = '0;
        case (i_speed)
            2'd1:    w_target_sel = c_duty_lo;
            2'd2:    w_target_sel = c_duty_mid;
            2'd3:    w_target_sel = c_duty_hi;
            default: w_target_sel = '0;
        endcase
    end

    // Next duty: step toward target without overshoot, or jump when not ramping
    always_comb begin
        w_diff = (r_target > r_duty) ? (r_target - r_duty) : (r_duty - r_target);
        if (!c_soft || (w_diff <= c_step)) begin
            w_duty_ramp = r_target;
        end else if (r_target > r_duty) begin
            w_duty_ramp = r_duty + c_step;
        end else begin
            w_duty_ramp = r_duty - c_step;
        end
        w_duty_nxt = w_period_end ? w_duty_ramp : r_duty;
    end

    // Target and duty registers; expiry forces a controlled ramp to zero
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_target <= '0;
            r_duty   <= '0;
        end else begin
            if (w_timeout) begin
                r_target <= '0;
            end else if (i_speed_valid) begin
                r_target <= w_target_sel;
            end
            r_duty <= w_duty_nxt;
        end
    end

    // Sequencer state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state; ramp completion is judged on the duty being written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_target != r_duty) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (w_duty_nxt == r_target) begin
                    w_state_nxt = (r_target == '0) ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_target != r_duty) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run timer: load beats decrement; expiry pulse aligns with reaching zero
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sec_cnt   <= '0;
            r_remaining <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (i_timer_load) begin
                r_remaining <= i_timer_set;
                r_sec_cnt   <= '0;
            end else if (w_timer_run && w_tick) begin
                if (w_sec_wrap) begin
                    r_sec_cnt   <= '0;
                    r_remaining <= r_remaining - 8'd1;
                end else begin
                    r_sec_cnt <= r_sec_cnt + c_sec_w'(1);
                end
            end
        end
    end

    // Registered PWM compare; duty only changes at the period wrap so no runts
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_pwm_cnt < r_duty);
        end
    end

    assign o_pwm       = r_pwm;
    assign o_duty      = r_duty;
    assign o_state     = r_state;
    assign o_remaining = r_remaining;
    assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_pwm_sequencer
// Description : Self-checking bench for motor_pwm_sequencer. Expected duty
//               values are queued when a speed command is issued and
//               compared as the duty output changes. Expectations follow
//               MOTOR_SOFT_START_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_sequencer;

    localparam int CLK_DIV    = 4;
    localparam int PWM_PERIOD = 10;
    localparam int STEP       = 2;
    localparam int DW         = $clog2(PWM_PERIOD + 1);
    localparam int PER_CYC    = CLK_DIV * PWM_PERIOD;

`ifdef MOTOR_SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    speed = 2'd0;
    logic          speed_valid = 1'b0;
    logic [7:0]    timer_set = 8'd0;
    logic          timer_load = 1'b0;
    logic          pwm;
    logic [DW-1:0] duty;
    logic [1:0]    state;
    logic [7:0]    remaining;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_timeout = 0;
    int exp_q[$];

    motor_pwm_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .PWM_PERIOD    (PWM_PERIOD),
        .DUTY_LO       (3),
        .DUTY_MID      (6),
        .DUTY_HI       (9),
        .RAMP_STEP     (STEP),
        .TICKS_PER_SEC (20)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_speed       (speed),
        .i_speed_valid (speed_valid),
        .i_timer_set   (timer_set),
        .i_timer_load  (timer_load),
        .o_pwm         (pwm),
        .o_duty        (duty),
        .o_state       (state),
        .o_remaining   (remaining),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; period ends fall on multiples of PER_CYC
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) cyc = 0;
            else     cyc = cyc + 1;
        end
    end

    // Scoreboard: every duty change must match the next queued value and land on a period end
    initial begin
        int prev;
        int e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
            end else begin
                if (timeout === 1'b1) n_timeout = n_timeout + 1;
                if (int'(duty) != prev) begin
                    checks = checks + 2;
                    if (exp_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL duty_unexpected: duty=%0d (was %0d), no change required", duty, prev);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(duty) !== e) begin
                            errors = errors + 1;
                            $display("FAIL duty_value: duty=%0d, required %0d", duty, e);
                        end
                    end
                    if (cyc % PER_CYC != 0) begin
                        errors = errors + 1;
                        $display("FAIL duty_timing: change at cycle %0d, required a multiple of %0d", cyc, PER_CYC);
                    end
                    prev = int'(duty);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Reference ramp: queue each duty value expected from 'from' to 'to'
    task automatic push_ramp(input int from, input int to);
        int d;
        d = from;
        while (d != to) begin
            if (SOFT) begin
                if (to > d) d = (to - d <= STEP) ? to : d + STEP;
                else        d = (d - to <= STEP) ? to : d - STEP;
            end else begin
                d = to;
            end
            exp_q.push_back(d);
        end
    endtask

    task automatic drive_speed(input logic [1:0] s);
        speed       = s;
        speed_valid = 1'b1;
        @(negedge clk);
        speed_valid = 1'b0;
    endtask

    task automatic align(input int off);
        while (cyc % PER_CYC != off) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, output int left);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int hi;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (pwm === 1'b1) hi = hi + 1;
        end
        checks = checks + 5;
        if (hi !== 0)             begin errors++; $display("FAIL reset_pwm_idle: high cycles=%0d, required 0", hi); end
        if (duty !== '0)          begin errors++; $display("FAIL reset_duty: duty=%0d, required 0", duty); end
        if (state !== 2'd0)       begin errors++; $display("FAIL reset_state: state=%0d, required 0", state); end
        if (remaining !== 8'd0)   begin errors++; $display("FAIL reset_remaining: remaining=%0d, required 0", remaining); end
        if (timeout !== 1'b0)     begin errors++; $display("FAIL reset_timeout: timeout=%0b, required 0", timeout); end
    endtask

    task automatic test_start();
        int bad;
        int n;
        int left;
        int hi;
        align(5);
        push_ramp(0, 9);
        drive_speed(2'd3);
        @(negedge clk);
        checks = checks + 2;
        if (state !== 2'd1) begin errors++; $display("FAIL start_enter_ramp: state=%0d, required 1", state); end
        if (duty !== '0)    begin errors++; $display("FAIL start_duty_hold: duty=%0d, required 0", duty); end
        bad = 0;
        n = 0;
        while (duty !== 4'd9 && n < 400) begin
            @(negedge clk);
            n = n + 1;
            if (duty !== 4'd9 && state !== 2'd1) bad = bad + 1;
        end
        wait_drain(80, left);
        checks = checks + 2;
        if (bad !== 0)  begin errors++; $display("FAIL start_ramp_state: %0d cycles not in RAMP, required 0", bad); end
        if (left !== 0) begin errors++; $display("FAIL start_drain: %0d duty values missing, required 0", left); end
        @(negedge clk);
        @(negedge clk);
        hi = 0;
        repeat (PER_CYC) begin
            @(negedge clk);
            if (pwm === 1'b1) hi = hi + 1;
        end
        checks = checks + 4;
        if (state !== 2'd2)   begin errors++; $display("FAIL start_run: state=%0d, required 2", state); end
        if (duty !== 4'd9)    begin errors++; $display("FAIL start_duty: duty=%0d, required 9", duty); end
        if (hi !== 36)        begin errors++; $display("FAIL start_pwm_high: high=%0d of 40, required 36", hi); end
        if (n_timeout !== 0)  begin errors++; $display("FAIL start_no_timeout: pulses=%0d, required 0", n_timeout); end
    endtask

    task automatic test_retarget();
        int left;
        push_ramp(9, 0);
        drive_speed(2'd0);
        wait_drain(400, left);
        @(negedge clk);
        checks = checks + 3;
        if (left !== 0)     begin errors++; $display("FAIL stop_drain: %0d duty values missing, required 0", left); end
        if (state !== 2'd0) begin errors++; $display("FAIL stop_idle: state=%0d, required 0", state); end
        if (duty !== '0)    begin errors++; $display("FAIL stop_duty: duty=%0d, required 0", duty); end
        align(5);
        if (SOFT) begin
            push_ramp(0, 6);
            drive_speed(2'd3);
            wait_drain(300, left);
            push_ramp(6, 3);
            drive_speed(2'd1);
        end else begin
            push_ramp(0, 3);
            drive_speed(2'd3);
            drive_speed(2'd1);
        end
        wait_drain(300, left);
        @(negedge clk);
        checks = checks + 3;
        if (left !== 0)     begin errors++; $display("FAIL retarget_drain: %0d duty values missing, required 0", left); end
        if (state !== 2'd2) begin errors++; $display("FAIL retarget_run: state=%0d, required 2", state); end
        if (duty !== 4'd3)  begin errors++; $display("FAIL retarget_duty: duty=%0d, required 3", duty); end
    endtask

    task automatic test_timeout();
        int left;
        int n;
        int t1;
        int t0;
        int nt0;
        push_ramp(3, 6);
        drive_speed(2'd2);
        wait_drain(300, left);
        @(negedge clk);
        checks = checks + 2;
        if (left !== 0)     begin errors++; $display("FAIL timer_setup_drain: %0d duty values missing, required 0", left); end
        if (state !== 2'd2) begin errors++; $display("FAIL timer_setup_run: state=%0d, required 2", state); end
        nt0 = n_timeout;
        timer_set  = 8'd2;
        timer_load = 1'b1;
        @(negedge clk);
        timer_load = 1'b0;
        checks = checks + 1;
        if (remaining !== 8'd2) begin errors++; $display("FAIL timer_load: remaining=%0d, required 2", remaining); end
        push_ramp(6, 0);
        n = 0;
        while (remaining !== 8'd1 && n < 200) begin @(negedge clk); n++; end
        t1 = cyc;
        checks = checks + 2;
        if (remaining !== 8'd1) begin errors++; $display("FAIL timer_first_sec: remaining=%0d, required 1", remaining); end
        if (timeout !== 1'b0)   begin errors++; $display("FAIL timer_early_pulse: timeout=%0b, required 0", timeout); end
        n = 0;
        while (remaining !== 8'd0 && n < 200) begin @(negedge clk); n++; end
        t0 = cyc;
        checks = checks + 3;
        if (remaining !== 8'd0) begin errors++; $display("FAIL timer_second_sec: remaining=%0d, required 0", remaining); end
        if (t0 - t1 !== 80)     begin errors++; $display("FAIL timer_spacing: %0d cycles, required 80", t0 - t1); end
        if (timeout !== 1'b1)   begin errors++; $display("FAIL timer_pulse: timeout=%0b, required 1", timeout); end
        @(negedge clk);
        checks = checks + 1;
        if (timeout !== 1'b0)   begin errors++; $display("FAIL timer_pulse_width: timeout=%0b, required 0", timeout); end
        wait_drain(400, left);
        @(negedge clk);
        checks = checks + 4;
        if (left !== 0)               begin errors++; $display("FAIL timer_rampdown: %0d duty values missing, required 0", left); end
        if (state !== 2'd0)           begin errors++; $display("FAIL timer_idle: state=%0d, required 0", state); end
        if (remaining !== 8'd0)       begin errors++; $display("FAIL timer_remaining_end: remaining=%0d, required 0", remaining); end
        if (n_timeout !== nt0 + 1)    begin errors++; $display("FAIL timer_pulse_count: pulses=%0d, required %0d", n_timeout, nt0 + 1); end
    endtask

    task automatic test_priority();
        int left;
        int ld;
        int tt;
        int nt0;
        // Speed command in the expiry cycle must not override the forced stop
        push_ramp(0, 6);
        drive_speed(2'd2);
        wait_drain(300, left);
        @(negedge clk);
        checks = checks + 2;
        if (left !== 0)     begin errors++; $display("FAIL prio_setup_drain: %0d duty values missing, required 0", left); end
        if (state !== 2'd2) begin errors++; $display("FAIL prio_setup_run: state=%0d, required 2", state); end
        align(5);
        timer_set  = 8'd1;
        timer_load = 1'b1;
        ld = cyc + 1;
        @(negedge clk);
        timer_load = 1'b0;
        tt = (ld / CLK_DIV + 1) * CLK_DIV + 19 * CLK_DIV;
        while (cyc < tt - 1) @(negedge clk);
        speed       = 2'd3;
        speed_valid = 1'b1;
        @(negedge clk);
        speed_valid = 1'b0;
        checks = checks + 2;
        if (timeout !== 1'b1)   begin errors++; $display("FAIL prio_timeout_pulse: timeout=%0b, required 1", timeout); end
        if (remaining !== 8'd0) begin errors++; $display("FAIL prio_timeout_remaining: remaining=%0d, required 0", remaining); end
        push_ramp(6, 0);
        wait_drain(400, left);
        repeat (PER_CYC * 2) @(negedge clk);
        checks = checks + 3;
        if (left !== 0)     begin errors++; $display("FAIL prio_rampdown: %0d duty values missing, required 0", left); end
        if (state !== 2'd0) begin errors++; $display("FAIL prio_stays_idle: state=%0d, required 0", state); end
        if (duty !== '0)    begin errors++; $display("FAIL prio_duty_zero: duty=%0d, required 0", duty); end
        // Load in the expiry cycle wins and suppresses the pulse
        push_ramp(0, 6);
        drive_speed(2'd2);
        wait_drain(300, left);
        @(negedge clk);
        checks = checks + 1;
        if (left !== 0) begin errors++; $display("FAIL load_setup_drain: %0d duty values missing, required 0", left); end
        nt0 = n_timeout;
        align(5);
        timer_set  = 8'd1;
        timer_load = 1'b1;
        ld = cyc + 1;
        @(negedge clk);
        timer_load = 1'b0;
        tt = (ld / CLK_DIV + 1) * CLK_DIV + 19 * CLK_DIV;
        while (cyc < tt - 1) @(negedge clk);
        timer_set  = 8'd5;
        timer_load = 1'b1;
        @(negedge clk);
        timer_load = 1'b0;
        checks = checks + 2;
        if (timeout !== 1'b0)   begin errors++; $display("FAIL load_beats_timeout: timeout=%0b, required 0", timeout); end
        if (remaining !== 8'd5) begin errors++; $display("FAIL load_value: remaining=%0d, required 5", remaining); end
        repeat (10) @(negedge clk);
        checks = checks + 3;
        if (n_timeout !== nt0) begin errors++; $display("FAIL load_no_pulse: pulses=%0d, required %0d", n_timeout, nt0); end
        if (state !== 2'd2)    begin errors++; $display("FAIL load_keeps_run: state=%0d, required 2", state); end
        if (duty !== 4'd6)     begin errors++; $display("FAIL load_keeps_duty: duty=%0d, required 6", duty); end
    endtask

    task automatic test_reset_mid();
        int left;
        int n;
        if (SOFT) begin
            push_ramp(6, 4);
            drive_speed(2'd0);
            wait_drain(200, left);
        end
        n = 0;
        while (pwm !== 1'b1 && n < 80) begin @(negedge clk); n++; end
        checks = checks + 2;
        if (duty !== (SOFT ? 4'd4 : 4'd6)) begin errors++; $display("FAIL rstmid_duty_before: duty=%0d, required %0d", duty, SOFT ? 4 : 6); end
        if (pwm !== 1'b1)                  begin errors++; $display("FAIL rstmid_pwm_before: pwm=%0b, required 1", pwm); end
        #2;
        rst = 1'b1;
        #1;
        checks = checks + 5;
        if (pwm !== 1'b0)       begin errors++; $display("FAIL rstmid_pwm: pwm=%0b, required 0", pwm); end
        if (duty !== '0)        begin errors++; $display("FAIL rstmid_duty: duty=%0d, required 0", duty); end
        if (state !== 2'd0)     begin errors++; $display("FAIL rstmid_state: state=%0d, required 0", state); end
        if (remaining !== 8'd0) begin errors++; $display("FAIL rstmid_remaining: remaining=%0d, required 0", remaining); end
        if (timeout !== 1'b0)   begin errors++; $display("FAIL rstmid_timeout: timeout=%0b, required 0", timeout); end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (PER_CYC + 5) @(negedge clk);
        checks = checks + 3;
        if (duty !== '0)    begin errors++; $display("FAIL rstmid_after_duty: duty=%0d, required 0", duty); end
        if (state !== 2'd0) begin errors++; $display("FAIL rstmid_after_state: state=%0d, required 0", state); end
        if (pwm !== 1'b0)   begin errors++; $display("FAIL rstmid_after_pwm: pwm=%0b, required 0", pwm); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_retarget();
        test_timeout();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
